// File: rtl/actuator_scheduler.sv
// Home-automation actuator arbiter: fire alarm has absolute priority, the other
// sources share the actuator slot round-robin, one grant per fixed hold period.
module actuator_scheduler #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned TEMP_LOW    = 15,
  parameter int unsigned TEMP_HIGH   = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SFA,
  input  logic       SW,
  input  logic       ST,
  input  logic [5:0] temperature,
  output logic [2:0] code,
  output logic       busy,
  output logic [5:0] pending
);

  typedef enum logic [1:0] {IDLE, SERVE, GAP} state_t;

  state_t     state_q, state_d;
  logic [2:0] src_q, src_d;
  logic [2:0] rr_q, rr_d;
  logic [2:0] code_q, code_d;
  logic       busy_q, busy_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] pend_q, pend_d;
  logic [5:0] req, clr;
  logic       win_found;
  logic [2:0] win_src;

  // Successor in the rotation 0,1,3,4,5; the alarm (2) hands on to 3.
  function automatic logic [2:0] rr_next(input logic [2:0] s);
    case (s)
      3'd1:    rr_next = 3'd3;
      3'd5:    rr_next = 3'd0;
      default: rr_next = s + 3'd1;
    endcase
  endfunction

  always_comb begin
    req = {ST && (32'(temperature) > TEMP_HIGH),
           ST && (32'(temperature) < TEMP_LOW),
           SW, SFA, SRD, SFD};
  end

  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_src   = '0;
    idx       = 0;
    if (pend_q[2]) begin
      win_found = 1'b1;
      win_src   = 3'd2;
    end else begin
      for (int unsigned k = 0; k < 6; k++) begin
        idx = (32'(rr_q) + k) % 6;
        if (!win_found && idx != 2 && pend_q[idx[2:0]]) begin
          win_found = 1'b1;
          win_src   = idx[2:0];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    clr     = '0;
    case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d = SERVE;
          src_d   = win_src;
          cnt_d   = 8'(HOLD_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        if (cnt_q == '0) begin
          clr[src_q] = 1'b1;
          rr_d       = rr_next(src_q);
          state_d    = GAP;
        end else if (pend_q[2] && src_q != 3'd2) begin
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A request on the completing edge re-pends its own source.
    pend_d = (pend_q & ~clr) | req;
    busy_d = (state_d == SERVE);
    code_d = busy_d ? src_d + 3'd1 : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      code_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
    end
  end

  assign code    = code_q;
  assign busy    = busy_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_actuator_scheduler.sv
// Self-checking bench for actuator_scheduler: directed scenarios plus random
// sensor traffic, all compared against a cycle-level behavioural model.
module tb_actuator_scheduler;

  localparam int HOLD = 8;
  localparam int TLOW = 15;
  localparam int THIGH = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       SFD, SRD, SFA, SW, ST;
  logic [5:0] temperature;
  logic [2:0] code;
  logic       busy;
  logic [5:0] pending;

  int total = 0;
  int bad = 0;

  // behavioural model
  bit       m_serv;
  int       m_src, m_left, m_rr;
  bit [5:0] m_pend;
  int       ord[5] = '{0, 1, 3, 4, 5};

  actuator_scheduler #(.HOLD_CYCLES(HOLD), .TEMP_LOW(TLOW), .TEMP_HIGH(THIGH)) dut (
    .clk(clk), .reset(reset), .SFD(SFD), .SRD(SRD), .SFA(SFA), .SW(SW), .ST(ST),
    .temperature(temperature), .code(code), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nxt(input int s);
    if (s == 5) return 0;
    if (s == 1) return 3;
    return s + 1;
  endfunction

  task automatic model_clear();
    m_serv = 0; m_src = 0; m_left = 0; m_rr = 0; m_pend = '0;
  endtask

  task automatic model_edge();
    bit [5:0] r;
    bit [5:0] np;
    int p;
    r[0] = SFD; r[1] = SRD; r[2] = SFA; r[3] = SW;
    r[4] = ST && (int'(temperature) < TLOW);
    r[5] = ST && (int'(temperature) > THIGH);
    np = m_pend;
    if (m_serv) begin
      if (m_left == 1) begin
        np[m_src] = 1'b0;
        m_rr = nxt(m_src);
        m_serv = 0;
      end else if (m_pend[2] && m_src != 2) begin
        m_serv = 0;
      end else begin
        m_left--;
      end
    end else if (m_pend[2]) begin
      m_serv = 1; m_src = 2; m_left = HOLD;
    end else begin
      p = 0;
      for (int i = 0; i < 5; i++) if (ord[i] == m_rr) p = i;
      for (int k = 0; k < 5; k++) begin
        if (!m_serv && m_pend[ord[(p + k) % 5]]) begin
          m_serv = 1; m_src = ord[(p + k) % 5]; m_left = HOLD;
        end
      end
    end
    m_pend = np | r;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("code", code, m_serv ? m_src + 1 : 0);
    chk("busy", busy, m_serv);
    chk("pending", pending, m_pend);
  endtask

  // Asynchronous reset applied between edges; outputs must clear before any edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_clear();
    chk("rst_code", code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pending, 0);
    #1 reset = 1'b1;
  endtask

  task automatic wait_code(input int c, input int lim);
    int n = 0;
    while (code !== 3'(c) && n < lim) begin
      step();
      n++;
    end
    chk("wait_code", code, c);
  endtask

  task automatic run_len(input int c, output int n);
    n = 0;
    while (code === 3'(c) && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pending !== 6'd0 || busy !== 1'b0) && n < 200) begin
      step();
      n++;
    end
    chk("drain", pending, 0);
  endtask

  initial begin
    int n;
    int seq[$];
    int prev;
    int exp_rr[6] = '{1, 2, 4, 1, 2, 4};

    reset = 1'b0;
    {SFD, SRD, SFA, SW, ST} = '0;
    temperature = 6'd20;
    model_clear();
    #3;
    chk("init_code", code, 0);
    chk("init_busy", busy, 0);
    chk("init_pend", pending, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // single window pulse
    SW = 1'b1;
    step();
    SW = 1'b0;
    step();
    chk("pulse_grant", code, 4);
    run_len(4, n);
    chk("pulse_len", n, HOLD);
    chk("pulse_pend3", pending[3], 0);
    step();
    chk("pulse_idle", code, 0);

    // round-robin fairness
    SFD = 1'b1; SRD = 1'b1; SW = 1'b1;
    prev = 0;
    for (int i = 0; i < 120 && seq.size() < 6; i++) begin
      step();
      if (code != 0 && int'(code) != prev) seq.push_back(int'(code));
      prev = int'(code);
    end
    chk("rr_count", seq.size(), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++) chk("rr_seq", seq[i], exp_rr[i]);
    SFD = 1'b0; SRD = 1'b0; SW = 1'b0;
    drain();

    // alarm preemption
    @(negedge clk);
    do_reset();
    SFD = 1'b1;
    step();
    SFD = 1'b0;
    step();
    chk("pre_grant1", code, 1);
    step();
    step();
    SFA = 1'b1;
    step();
    SFA = 1'b0;
    step();
    chk("pre_gap", code, 0);
    step();
    chk("pre_alarm", code, 3);
    run_len(3, n);
    chk("pre_alarm_len", n, HOLD);
    chk("pre_pend0", pending[0], 1);
    step();
    chk("pre_resume", code, 1);
    run_len(1, n);
    chk("pre_resume_len", n, HOLD);
    drain();

    // temperature thresholds
    ST = 1'b1;
    temperature = 6'd15;
    for (int i = 0; i < 4; i++) step();
    chk("t15", code, 0);
    temperature = 6'd14;
    step();
    temperature = 6'd20;
    step();
    chk("t14", code, 5);
    drain();
    temperature = 6'd30;
    for (int i = 0; i < 4; i++) step();
    chk("t30", code, 0);
    temperature = 6'd31;
    step();
    temperature = 6'd20;
    step();
    chk("t31", code, 6);
    drain();
    ST = 1'b0;
    temperature = 6'd0;
    for (int i = 0; i < 4; i++) step();
    chk("st_off", code, 0);
    temperature = 6'd20;

    // request held across its own completion
    SFD = 1'b1;
    wait_code(1, 10);
    run_len(1, n);
    chk("hold_len", n, HOLD);
    chk("hold_pend0", pending[0], 1);
    step();
    chk("hold_resume", code, 1);
    SFD = 1'b0;
    drain();

    // reset in the middle of a service
    SW = 1'b1;
    step();
    SW = 1'b0;
    wait_code(4, 10);
    step();
    step();
    #2;
    do_reset();
    step();
    chk("post_rst", code, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      SFD = ($urandom_range(0, 15) == 0);
      SRD = ($urandom_range(0, 15) == 0);
      SFA = ($urandom_range(0, 59) == 0);
      SW  = ($urandom_range(0, 15) == 0);
      ST  = ($urandom_range(0, 3) == 0);
      temperature = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/actuator_scheduler.md
# actuator_scheduler

Sequences the home-automation actuators by arbitrating among sensor requests (doors, fire alarm, window, temperature) and granting exactly one actuator at a time for a fixed hold period. The fire alarm takes absolute priority; all other sources share the actuator slot round-robin. The 3-bit `code` output uses the existing output-decoder encoding, so it replaces the counter/priority-encoder path ahead of the state register and output decoder.

## Interface
- `HOLD_CYCLES`, 8: cycles a granted actuator stays active; legal range is 2..255.
- `TEMP_LOW`, 15: heater requested when `temperature < TEMP_LOW`.
- `TEMP_HIGH`, 30: cooler requested when `temperature > TEMP_HIGH`; must satisfy `TEMP_LOW < TEMP_HIGH`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- `SFD` in 1: front-door sensor, source 0.
- `SRD` in 1: rear-door sensor, source 1.
- `SFA` in 1: fire-alarm sensor, source 2 (priority source).
- `SW` in 1: window sensor, source 3.
- `ST` in 1: temperature-sensor enable; gates sources 4 and 5.
- `temperature` in 6: unsigned temperature value.
- `code` out 3: active actuator. 0 idle, 1 front_door, 2 rear_door, 3 alarm_buzzer, 4 window_buzzer, 5 heater, 6 cooler. 7 never occurs.
- `busy` out 1: high in SERVE.
- `pending` out 6: sticky request flags, one bit per source 0..5.

## Operation
- **Requests**
  - `req[0..3]` are `SFD`, `SRD`, `SFA`, `SW`.
  - `req[4]` = `ST & (temperature < TEMP_LOW)`.
  - `req[5]` = `ST & (temperature > TEMP_HIGH)`.
  - Comparisons are strict and unsigned. `req[4]` and `req[5]` are never both high.
- **Pending**
  - `pending[i]` is set on any edge where `req[i]` is 1.
  - It is cleared only on the edge where source i completes its full hold.
  - Setting wins over clearing on the same edge.
- **FSM states:** IDLE, SERVE, GAP.
  - **IDLE** (`code`=0):
    - If `pending[2]`, go to SERVE with source 2.
    - Otherwise, if any other pending bit is set, go to SERVE with the round-robin winner.
    - Otherwise stay in IDLE.
  - **SERVE** (`code`=source+1, `busy`=1):
    - The hold counter loads `HOLD_CYCLES-1` on entry and decrements each cycle.
    - At count 0: clear `pending[src]`, set `rr_ptr` to the source after `src`, go to GAP.
  - **Preemption:** if `pending[2]` is set while serving a non-alarm source, go to GAP on the next edge. The preempted source's pending bit stays set, and `rr_ptr` is unchanged.
  - **GAP** (`code`=0, `busy`=0): lasts exactly 1 cycle as actuator dead time. It arbitrates like IDLE and goes to SERVE or IDLE.
- **Round-robin**
  - Order is 0, 1, 3, 4, 5; source 2 is excluded.
  - The search starts at `rr_ptr` and wraps from 5 to 0. `rr_ptr` skips the value 2.
  - The alarm never preempts itself. Back-to-back alarms are separated by a GAP.
- **Reset** (`reset`=0) clears everything immediately, including mid-SERVE: state=IDLE, `code`=0, `busy`=0, `pending`=0, `rr_ptr`=0, hold counter=0.
- Outputs are registered only, with no combinational path from inputs to `code`.

## Timing
- Minimum latency from request to grant is 2 edges:
  - `req` high before edge k sets `pending` at edge k.
  - The grant appears on `code` after edge k+1.
- SERVE lasts exactly `HOLD_CYCLES` cycles unless preempted. The alarm grant appears 2 cycles after the preempting edge (SERVE, then GAP, then SERVE alarm).
- Back-to-back service period is `HOLD_CYCLES` + 1 cycles.
- A 1-cycle request pulse is never lost. It is held in `pending` until served.
- If a request is still high when its service completes, it re-pends on that edge and is served again only after the other pending sources (round-robin).
- Reset release is synchronous to `clk`. The first state update happens on the first rising edge after `reset` goes to 1.

## Test plan
- **Reset mid-SERVE:** reset pulse while `code`=4 → `code`=0, `busy`=0, `pending`=0 immediately, before any clock edge.
- **Single pulse:** `SW` pulsed for 1 cycle with `HOLD_CYCLES`=8 → `code`=4 appears 2 edges later and lasts exactly 8 cycles, then GAP with `code`=0, then IDLE. `pending[3]` clears at the end.
- **Round-robin fairness:** `SFD`, `SRD` and `SW` held high → `code` sequence 1, 2, 4, 1, 2, 4 with a 1-cycle 0 between each grant.
- **Alarm preemption:** `SFA` pulsed at cycle 3 of a `code`=1 grant → `code`=0 for 1 cycle, then `code`=3 for 8 cycles. After that, `code`=1 is served again with a full 8 cycles, and `pending[0]` stays set until then.
- **Temperature boundaries:** with `ST`=1:
  - `temperature`=15 → no heater request.
  - `temperature`=14 → `code`=5.
  - `temperature`=30 → no cooler request.
  - `temperature`=31 → `code`=6.
  - `ST`=0 with `temperature`=0 → `code` stays 0.
- **Simultaneous pend and clear:** `SFD` held high across the end of its own service → `pending[0]` remains 1. With no other requests, `code`=1 resumes after the GAP.
